// File: rtl/guess_judge.sv
// Number-baseball guess judge: collects 3-digit guesses from the on-turn player, scores strikes/balls,
// alternates turns and detects win/draw. Optional turn timeout enabled by defining GUESS_TIMEOUT_EN.
module guess_judge #(
  parameter int unsigned MAX_TURNS      = 9,
  parameter int unsigned DIGIT_MAX      = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        guess_mode,
  input  logic [3:0]  digit_in,
  input  logic        button_released_p1,
  input  logic        button_released_p2,
  input  logic [11:0] secret_p1,
  input  logic [11:0] secret_p2,
  output logic        turn,
  output logic [1:0]  digit_cnt,
  output logic [11:0] guess_out,
  output logic        digit_err,
  output logic [1:0]  strike,
  output logic [1:0]  ball,
  output logic        result_valid,
  output logic        result_player,
  output logic [3:0]  turn_cnt_p1,
  output logic [3:0]  turn_cnt_p2,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        timeout_pulse
);

  localparam logic [3:0] MaxTurns = 4'(MAX_TURNS);
  localparam logic [3:0] DigitMax = 4'(DIGIT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_JUDGE, S_REPORT, S_OVER} state_e;

  state_e      state_q;
  logic        turn_q;
  logic [1:0]  digit_cnt_q;
  logic [11:0] guess_q;
  logic        digit_err_q;
  logic [1:0]  strike_q;
  logic [1:0]  ball_q;
  logic        result_valid_q;
  logic        result_player_q;
  logic [3:0]  cnt_p1_q;
  logic [3:0]  cnt_p2_q;
  logic        game_over_q;
  logic [1:0]  winner_q;

  logic        pulse_c;
  logic        dup_c;
  logic        bad_c;
  logic        accept_c;
  logic        reject_c;
  logic        expire_c;
  logic [11:0] secret_sel;
  logic [1:0]  strike_d;
  logic [1:0]  ball_d;
  logic [3:0]  cnt_p1_d;
  logic [3:0]  cnt_p2_d;

  // Only the on-turn player's release is honoured; digits must be legal and unique in the guess.
  assign pulse_c  = turn_q ? button_released_p2 : button_released_p1;
  assign dup_c    = ((digit_cnt_q != 2'd0) && (digit_in == guess_q[3:0])) ||
                    ((digit_cnt_q == 2'd2) && (digit_in == guess_q[7:4]));
  assign bad_c    = (digit_in > DigitMax) || dup_c;
  assign accept_c = (state_q == S_COLLECT) && guess_mode && pulse_c && !bad_c;
  assign reject_c = (state_q == S_COLLECT) && guess_mode && pulse_c && bad_c;

  assign secret_sel = turn_q ? secret_p1 : secret_p2;

  always_comb begin
    strike_d = 2'd0;
    ball_d   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (guess_q[4*i +: 4] == secret_sel[4*j +: 4]) begin
          if (i == j) strike_d = strike_d + 2'd1;
          else        ball_d   = ball_d + 2'd1;
        end
      end
    end
  end

  // Saturating per-player guess counts applied when leaving REPORT.
  assign cnt_p1_d = (!turn_q && (cnt_p1_q != MaxTurns)) ? cnt_p1_q + 4'd1 : cnt_p1_q;
  assign cnt_p2_d = ( turn_q && (cnt_p2_q != MaxTurns)) ? cnt_p2_q + 4'd1 : cnt_p2_q;

`ifdef GUESS_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] to_cnt_q;
  logic          timeout_q;

  assign expire_c = (state_q == S_COLLECT) && guess_mode && !accept_c &&
                    (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter restarts outside COLLECT (covers every turn change) and on each accepted digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire_c;
      if ((state_q != S_COLLECT) || accept_c) to_cnt_q <= '0;
      else                                     to_cnt_q <= to_cnt_q + TW'(1);
    end
  end

  assign timeout_pulse = timeout_q;
`else
  assign expire_c      = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      turn_q          <= 1'b0;
      digit_cnt_q     <= 2'd0;
      guess_q         <= 12'h000;
      digit_err_q     <= 1'b0;
      strike_q        <= 2'd0;
      ball_q          <= 2'd0;
      result_valid_q  <= 1'b0;
      result_player_q <= 1'b0;
      cnt_p1_q        <= 4'd0;
      cnt_p2_q        <= 4'd0;
      game_over_q     <= 1'b0;
      winner_q        <= 2'b00;
    end else begin
      digit_err_q    <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (guess_mode) state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          if (!guess_mode) begin
            digit_cnt_q <= 2'd0;
            guess_q     <= 12'h000;
            state_q     <= S_IDLE;
          end else if (accept_c) begin
            guess_q <= {guess_q[7:0], digit_in};
            if (digit_cnt_q == 2'd2) begin
              digit_cnt_q <= 2'd0;
              state_q     <= S_JUDGE;
            end else begin
              digit_cnt_q <= digit_cnt_q + 2'd1;
            end
          end else begin
            if (reject_c) digit_err_q <= 1'b1;
            // Forfeit: report a 0/0 result for the on-turn player.
            if (expire_c) begin
              digit_cnt_q     <= 2'd0;
              guess_q         <= 12'h000;
              strike_q        <= 2'd0;
              ball_q          <= 2'd0;
              result_player_q <= turn_q;
              result_valid_q  <= 1'b1;
              state_q         <= S_REPORT;
            end
          end
        end
        S_JUDGE: begin
          strike_q        <= strike_d;
          ball_q          <= ball_d;
          result_player_q <= turn_q;
          result_valid_q  <= 1'b1;
          state_q         <= S_REPORT;
        end
        S_REPORT: begin
          cnt_p1_q <= cnt_p1_d;
          cnt_p2_q <= cnt_p2_d;
          if (strike_q == 2'd3) begin
            winner_q    <= turn_q ? 2'b10 : 2'b01;
            game_over_q <= 1'b1;
            state_q     <= S_OVER;
          end else if ((cnt_p1_d == MaxTurns) && (cnt_p2_d == MaxTurns)) begin
            winner_q    <= 2'b11;
            game_over_q <= 1'b1;
            state_q     <= S_OVER;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= S_COLLECT;
          end
        end
        S_OVER: begin
          state_q <= S_OVER;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign turn          = turn_q;
  assign digit_cnt     = digit_cnt_q;
  assign guess_out     = guess_q;
  assign digit_err     = digit_err_q;
  assign strike        = strike_q;
  assign ball          = ball_q;
  assign result_valid  = result_valid_q;
  assign result_player = result_player_q;
  assign turn_cnt_p1   = cnt_p1_q;
  assign turn_cnt_p2   = cnt_p2_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_guess_judge.sv
// Directed bench for guess_judge (MAX_TURNS=2, TIMEOUT_CYCLES=20); timeout steps depend on GUESS_TIMEOUT_EN.
module tb_guess_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        guess_mode;
  logic [3:0]  digit_in;
  logic        bp1;
  logic        bp2;
  logic [11:0] secret_p1;
  logic [11:0] secret_p2;
  logic        turn;
  logic [1:0]  digit_cnt;
  logic [11:0] guess_out;
  logic        digit_err;
  logic [1:0]  strike;
  logic [1:0]  ball;
  logic        result_valid;
  logic        result_player;
  logic [3:0]  turn_cnt_p1;
  logic [3:0]  turn_cnt_p2;
  logic        game_over;
  logic [1:0]  winner;
  logic        timeout_pulse;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  guess_judge #(.MAX_TURNS(2), .DIGIT_MAX(9), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .guess_mode(guess_mode), .digit_in(digit_in),
    .button_released_p1(bp1), .button_released_p2(bp2),
    .secret_p1(secret_p1), .secret_p2(secret_p2),
    .turn(turn), .digit_cnt(digit_cnt), .guess_out(guess_out), .digit_err(digit_err),
    .strike(strike), .ball(ball), .result_valid(result_valid), .result_player(result_player),
    .turn_cnt_p1(turn_cnt_p1), .turn_cnt_p2(turn_cnt_p2), .game_over(game_over),
    .winner(winner), .timeout_pulse(timeout_pulse)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] all_outs();
    return 40'({turn, digit_cnt, guess_out, digit_err, strike, ball, result_valid, result_player,
                turn_cnt_p1, turn_cnt_p2, game_over, winner, timeout_pulse});
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; guess_mode = 1'b0; bp1 = 1'b0; bp2 = 1'b0; digit_in = 4'd0;
    step(); step();
    chk(tag, all_outs(), 40'd0);
    rst = 1'b0;
    step();
    guess_mode = 1'b1;
    step();
  endtask

  task automatic press(input logic p, input logic [3:0] d);
    digit_in = d;
    if (p) bp2 = 1'b1; else bp1 = 1'b1;
    step();
    bp1 = 1'b0; bp2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    secret_p1 = 12'h456;
    secret_p2 = 12'h123;

    // P1 wins on the first guess
    do_reset("reset_all_zero");
    press(1'b0, 4'd1); press(1'b0, 4'd2); press(1'b0, 4'd3);
    chk("win_guess_out", 40'(guess_out), 40'h123);
    chk("win_cnt_after_3", 40'(digit_cnt), 40'd0);
    chk("win_no_valid_in_judge", 40'(result_valid), 40'd0);
    step();
    chk("win_report", 40'({result_valid, strike, ball, result_player}), 40'({1'b1, 2'd3, 2'd0, 1'b0}));
    step();
    chk("win_over", 40'({game_over, winner, turn_cnt_p1, result_valid}), 40'({1'b1, 2'b01, 4'd1, 1'b0}));

    // Alternating guesses ending in a draw at MAX_TURNS=2
    do_reset("reset_2");
    press(1'b0, 4'd3); press(1'b0, 4'd1); press(1'b0, 4'd2);
    step();
    chk("p1_all_balls", 40'({result_valid, strike, ball, result_player}), 40'({1'b1, 2'd0, 2'd3, 1'b0}));
    step();
    chk("turn_to_p2", 40'({turn, turn_cnt_p1, game_over}), 40'({1'b1, 4'd1, 1'b0}));
    press(1'b1, 4'd4); press(1'b1, 4'd6); press(1'b1, 4'd5);
    step();
    chk("p2_1s2b", 40'({result_valid, strike, ball, result_player}), 40'({1'b1, 2'd1, 2'd2, 1'b1}));
    step();
    chk("turn_to_p1", 40'({turn, turn_cnt_p2}), 40'({1'b0, 4'd1}));
    press(1'b0, 4'd1); press(1'b0, 4'd3); press(1'b0, 4'd2);
    step();
    chk("p1_1s2b", 40'({strike, ball, result_player}), 40'({2'd1, 2'd2, 1'b0}));
    step();
    press(1'b1, 4'd5); press(1'b1, 4'd6); press(1'b1, 4'd4);
    step();
    chk("p2_0s3b", 40'({result_valid, strike, ball}), 40'({1'b1, 2'd0, 2'd3}));
    step();
    chk("draw", 40'({game_over, winner, turn_cnt_p1, turn_cnt_p2, turn}), 40'({1'b1, 2'b11, 4'd2, 4'd2, 1'b1}));
    press(1'b1, 4'd7); press(1'b0, 4'd8);
    chk("over_frozen", 40'({digit_cnt, guess_out, result_valid, winner, turn_cnt_p2, digit_err}),
        40'({2'd0, 12'h564, 1'b0, 2'b11, 4'd2, 1'b0}));

    // Digit rejection: duplicate and out-of-range
    do_reset("reset_3");
    press(1'b0, 4'd7);
    chk("first_7", 40'({digit_cnt, guess_out, digit_err}), 40'({2'd1, 12'h007, 1'b0}));
    press(1'b0, 4'd7);
    chk("dup_7_err", 40'({digit_cnt, guess_out, digit_err}), 40'({2'd1, 12'h007, 1'b1}));
    press(1'b0, 4'd10);
    chk("digit_10_err", 40'({digit_cnt, guess_out, digit_err}), 40'({2'd1, 12'h007, 1'b1}));
    step();
    chk("err_one_cycle", 40'(digit_err), 40'd0);

    // Off-turn pulses ignored, including simultaneous pulses
    do_reset("reset_4");
    press(1'b1, 4'd5);
    chk("offturn_ignored", 40'({digit_cnt, digit_err}), 40'({2'd0, 1'b0}));
    digit_in = 4'd5; bp1 = 1'b1; bp2 = 1'b1;
    step();
    bp1 = 1'b0; bp2 = 1'b0;
    chk("both_pulses", 40'({digit_cnt, guess_out}), 40'({2'd1, 12'h005}));

    // Leaving guess_mode mid-guess keeps turn and last result
    do_reset("reset_5");
    press(1'b0, 4'd3); press(1'b0, 4'd1); press(1'b0, 4'd2);
    step(); step();
    press(1'b1, 4'd4); press(1'b1, 4'd5);
    chk("two_digits", 40'(digit_cnt), 40'd2);
    guess_mode = 1'b0;
    step();
    chk("mode_drop", 40'({digit_cnt, guess_out, turn, strike, ball}), 40'({2'd0, 12'h000, 1'b1, 2'd0, 2'd3}));
    guess_mode = 1'b1;
    step();
    press(1'b1, 4'd4); press(1'b1, 4'd5); press(1'b1, 4'd6);
    step();
    chk("p2_win_report", 40'({result_valid, strike, result_player}), 40'({1'b1, 2'd3, 1'b1}));
    step();
    chk("p2_win", 40'({game_over, winner, turn_cnt_p2}), 40'({1'b1, 2'b10, 4'd1}));

    // Asynchronous reset during REPORT
    do_reset("reset_6");
    press(1'b0, 4'd1); press(1'b0, 4'd2); press(1'b0, 4'd3);
    step();
    chk("in_report", 40'(result_valid), 40'd1);
    rst = 1'b1;
    #1;
    chk("async_rst", all_outs(), 40'd0);

`ifdef GUESS_TIMEOUT_EN
    do_reset("reset_7");
    for (int i = 0; i < 19; i++) step();
    chk("no_timeout_yet", 40'(timeout_pulse), 40'd0);
    step();
    chk("timeout", 40'({timeout_pulse, result_valid, strike, ball, result_player}),
        40'({1'b1, 1'b1, 2'd0, 2'd0, 1'b0}));
    step();
    chk("timeout_turn", 40'({turn, turn_cnt_p1, timeout_pulse}), 40'({1'b1, 4'd1, 1'b0}));
`else
    do_reset("reset_7");
    for (int i = 0; i < 30; i++) step();
    chk("no_timeout_feature", 40'({timeout_pulse, turn, result_valid}), 40'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/guess_judge.md
Name: guess_judge

Overview:
- Downstream consumer of the per-player button release pulses in the two-player number-baseball game.
- On each release pulse from the player whose turn it is, accepts one decimal digit from the shared digit bus and assembles it into a 3-digit guess.
- Scores the completed guess against the opponent's secret (strikes/balls), alternates turns, and detects a win, a draw, or a turn limit.

Parameters:
- MAX_TURNS, 9, guesses allowed per player before a draw is declared (1..15).
- DIGIT_MAX, 9, largest legal digit value.
- TIMEOUT_CYCLES, 1000000, idle cycles before the turn is forfeited (used only with GUESS_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- guess_mode  input  1  guessing phase enable
- digit_in  input  4  digit currently selected on the switches
- button_released_p1  input  1  one-cycle release pulse, player 1
- button_released_p2  input  1  one-cycle release pulse, player 2
- secret_p1  input  12  player 1 secret, digits [11:8],[7:4],[3:0]; stable during guess_mode
- secret_p2  input  12  player 2 secret, same packing
- turn  output  1  0 = player 1 to guess, 1 = player 2
- digit_cnt  output  2  digits accepted in the current guess (0..2)
- guess_out  output  12  guess being assembled; holds the last guess after scoring
- digit_err  output  1  one-cycle pulse when an entered digit is rejected
- strike  output  2  strikes of the last scored guess
- ball  output  2  balls of the last scored guess
- result_valid  output  1  one-cycle pulse when strike/ball update
- result_player  output  1  player whose guess produced the current strike/ball values
- turn_cnt_p1  output  4  guesses scored for player 1
- turn_cnt_p2  output  4  guesses scored for player 2
- game_over  output  1  level, high once the game has ended
- winner  output  2  00 none, 01 p1, 10 p2, 11 draw
- timeout_pulse  output  1  one-cycle pulse when a turn is forfeited (0 without the macro)

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst asserted at any time, including mid-guess or mid-report: every output goes to 0 and the FSM enters IDLE.
- States:
  - IDLE: entered from reset; holds while guess_mode=0. When guess_mode=1, go to COLLECT.
  - COLLECT: accepts digits from the on-turn player.
  - JUDGE: one cycle; strike/ball computed and registered.
  - REPORT: one cycle with result_valid=1.
  - OVER: terminal; left only by reset.
- Leaving guess_mode:
  - guess_mode=0 in COLLECT: discard the partial guess (digit_cnt=0, guess_out=0) and go to IDLE.
  - turn, the turn counts and the last strike/ball values are kept.
  - guess_mode is ignored in JUDGE, REPORT and OVER.
- Digit entry (COLLECT only):
  - Only the pulse of the on-turn player is honoured. The off-turn pulse is ignored, including when both pulses arrive in the same cycle.
  - An honoured pulse is rejected if digit_in > DIGIT_MAX or digit_in equals a digit already accepted in this guess. On rejection: digit_err=1 for one cycle; guess_out and digit_cnt are unchanged.
  - Otherwise the digit is shifted in MSB-first, guess_out = {guess_out[7:0], digit_in}, and digit_cnt increments.
  - On the third accepted digit: digit_cnt returns to 0 and the FSM goes to JUDGE.
- Scoring:
  - Player 1 is scored against secret_p2; player 2 against secret_p1.
  - strike = count of positions with equal digits.
  - ball = count of guess digits present in the secret at a different position.
  - Digits are unique, so strike+ball <= 3.
  - Registered on the edge that leaves JUDGE; result_player = turn at that point.
- Latency:
  - Third digit accepted at edge k.
  - result_valid=1 in the cycle after edge k+1.
  - The turn swap or game_over is visible after edge k+2.
- After REPORT:
  - Increment the on-turn player's turn count.
  - If strike==3: winner = that player, go to OVER.
  - Else if both counts equal MAX_TURNS: winner=11, go to OVER.
  - Else toggle turn and return to COLLECT.
- Hold behaviour:
  - Counts saturate at MAX_TURNS.
  - strike, ball and result_player hold until the next REPORT.

Optional Feature:
- Macro: GUESS_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in COLLECT and restarts on every accepted digit and on every turn change.
  - When it reaches TIMEOUT_CYCLES: discard the partial guess, pulse timeout_pulse, and go to REPORT with strike=0, ball=0.
  - The forfeited turn counts as a scored guess.
  - A digit accepted in the same cycle as expiry takes priority and restarts the counter.
- Without the macro: no counter is present and timeout_pulse is tied to 0.

Test Plan:
- Reset, then guess_mode=1, secret_p2=0x123. P1 enters 1,2,3 → result_valid one cycle with strike=3, ball=0, result_player=0; then game_over=1, winner=01, turn_cnt_p1=1.
- secret_p1=0x456. P1 guesses 3,1,2 against secret_p2=0x123 → strike=0, ball=3, turn becomes 1. P2 guesses 4,6,5 → strike=1, ball=2.
- P1 enters 7, then 7 again, then digit 10 → two digit_err pulses; digit_cnt stays 1 and guess_out=0x007.
- On P1's turn, pulse p2 alone, then p1 and p2 in the same cycle → only the p1 digit is accepted; digit_cnt=1.
- MAX_TURNS=2 with no strike-3 guesses → after the 4th REPORT, winner=11 and game_over=1. Further pulses cause no change.
- Drop guess_mode after 2 digits → digit_cnt=0 and turn is unchanged. Assert rst during REPORT → all outputs 0. With GUESS_TIMEOUT_EN and TIMEOUT_CYCLES=20: after 20 idle cycles, timeout_pulse=1, strike=0, and turn toggles.
